log_issue: RTL and testbench
============================

# log_issue

Command queue and issue sequencer that sits directly upstream of the 16-bit integer logic unit. It accepts logic commands over a valid/ready handshake, buffers them in a small FIFO and drives one command at a time onto the logic unit's operation/operand inputs. It waits a programmable settle latency, captures the logic unit result and presents it downstream on a second valid/ready handshake. Illegal opcode 3'b111 is trapped locally and flagged, never issued.

## Interface
Parameters:
- DEPTH, 4: command FIFO entries; power of two, 2..16.
- LAT, 1: logic-unit settle cycles before capture; 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  command present.
- in_ready  out  1  FIFO can accept; equals !full, forced 0 while rst high.
- in_op  in  3  opcode: 000 AND, 001 NAND, 010 OR, 011 NOR, 100 XOR, 101 XNOR, 110 NOT A, 111 illegal.
- in_opa, in_opb  in  16  operands.
- log_op  out  3  registered opcode to logic unit.
- log_opa, log_opb  out  16  registered operands to logic unit.
- log_out  in  16  logic unit result.
- res_valid  out  1  result held.
- res_ready  in  1  downstream accepts.
- res_data  out  16  captured result.
- res_err  out  1  result came from illegal opcode.
- busy  out  1  (state != IDLE) or FIFO non-empty.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- FIFO: push on in_valid && in_ready. Pop only by FSM in IDLE. Push and pop in same cycle keep count unchanged. in_ready is from registered count; no full-bypass, so a pop does not make in_ready high in the same cycle it happens.
- Pointers wrap modulo DEPTH; count never exceeds DEPTH, never underflows.
- FSM states IDLE, WAIT, HOLD:
  - IDLE, count==0: stay.
  - IDLE, count>0, head op != 111: pop; load log_op/log_opa/log_opb from head; wait counter <= LAT; go WAIT.
  - IDLE, count>0, head op == 111: pop; log_* unchanged; res_data <= 0, res_err <= 1, res_valid <= 1; go HOLD.
  - WAIT: counter != 0 -> decrement. Counter == 0 -> res_data <= log_out, res_err <= 0, res_valid <= 1; go HOLD.
  - HOLD: res_valid && res_ready -> res_valid <= 0; go IDLE. Otherwise res_data/res_err held stable.
- log_* keep the last issued command after completion; they change only on an issue pop.
- Results are emitted strictly in acceptance order.

## Timing
- Reset: all outputs 0, i.e. in_ready, log_op, log_opa, log_opb, res_valid, res_data, res_err, busy and count. FIFO is flushed and the FSM goes to IDLE. in_ready rises the first cycle after rst falls.
- Reset mid-operation (WAIT or HOLD) discards the in-flight command and all queued commands. No result is emitted.
- Legal command accepted at edge 0 into an empty idle block:
  - Popped and issued at edge 1.
  - Captured at edge LAT+2; res_valid is visible after that edge, which is 3 cycles for LAT=1.
- Illegal command accepted at edge 0: res_valid is visible after edge 1.
- Throughput: one result per LAT+3 cycles with res_ready held high; one per 2 cycles for illegal opcodes.
- A push arriving while the FSM is in WAIT or HOLD is queued. The head is popped on the first IDLE cycle.

## Test plan
- Single AND, LAT=1: in_op=000, opa=F0F0, opb=FF00 accepted at edge 0 -> res_valid after edge 3, res_data=F000, res_err=0; res_valid clears on the edge where res_ready=1.
- Backpressure fill, DEPTH=4, res_ready=0, opa=1234, opb=00FF: push NAND, OR, NOR, XOR, XNOR.
  - 5 accepts succeed: 1 command in HOLD, 4 in FIFO.
  - in_ready=0 with count=4.
  - Release res_ready -> results in order FFCB, 12FF, ED00, 12CB, ED34.
- Illegal then legal: op=111 then op=110 with opa=00FF -> first res_data=0000, res_err=1 one cycle after accept, log_op never 111; second res_data=FF00, res_err=0.
- Stall hold: result valid with res_ready low for 10 cycles -> res_valid, res_data, res_err constant; busy=1.
- Reset mid-WAIT: one command in WAIT and two queued; pulse rst for 1 cycle -> all outputs 0, count=0, no res_valid afterwards, in_ready=1 the next cycle.
- Full plus simultaneous activity: FIFO full, in_valid=1 held, IDLE pop occurs -> push blocked on the pop cycle, accepted the following cycle, count returns to DEPTH.

Source files
------------

// File: rtl/log_issue.sv
// Command queue and issue sequencer in front of the 16-bit logic unit: buffers
// commands, issues one at a time, waits LAT cycles, then holds the captured result.
//
// state | meaning
// IDLE  | no command in flight; pops the FIFO head when one is queued
// WAIT  | command driven on log_*; counting down the logic-unit settle time
// HOLD  | result (or illegal-opcode trap) presented until res_ready
module log_issue #(
    parameter int DEPTH = 4,
    parameter int LAT   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [15:0]              in_opa,
    input  logic [15:0]              in_opb,
    output logic [2:0]               log_op,
    output logic [15:0]              log_opa,
    output logic [15:0]              log_opb,
    input  logic [15:0]              log_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [15:0]              res_data,
    output logic                     res_err,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    logic [2:0]  fifo_op_q  [DEPTH];
    logic [15:0] fifo_opa_q [DEPTH];
    logic [15:0] fifo_opb_q [DEPTH];
    logic [2:0]  fifo_op_d  [DEPTH];
    logic [15:0] fifo_opa_d [DEPTH];
    logic [15:0] fifo_opb_d [DEPTH];

    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    wait_q, wait_d;
    logic [2:0]    log_op_q, log_op_d;
    logic [15:0]   log_opa_q, log_opa_d;
    logic [15:0]   log_opb_q, log_opb_d;
    logic          res_valid_q, res_valid_d;
    logic [15:0]   res_data_q, res_data_d;
    logic          res_err_q, res_err_d;

    logic          push;
    logic          pop;

    // in_ready depends only on the registered count: a pop never frees a slot combinationally
    assign in_ready  = !rst && (count_q != CW'(DEPTH));
    assign busy      = (state_q != IDLE) || (count_q != '0);
    assign count     = count_q;
    assign log_op    = log_op_q;
    assign log_opa   = log_opa_q;
    assign log_opb   = log_opb_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;

    always_comb begin
        push        = in_valid && in_ready;
        pop         = (state_q == IDLE) && (count_q != '0);

        fifo_op_d   = fifo_op_q;
        fifo_opa_d  = fifo_opa_q;
        fifo_opb_d  = fifo_opb_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        state_d     = state_q;
        wait_d      = wait_q;
        log_op_d    = log_op_q;
        log_opa_d   = log_opa_q;
        log_opb_d   = log_opb_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_err_d   = res_err_q;

        if (push) begin
            fifo_op_d[wr_ptr_q]  = in_op;
            fifo_opa_d[wr_ptr_q] = in_opa;
            fifo_opb_d[wr_ptr_q] = in_opb;
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (pop) begin
                    if (fifo_op_q[rd_ptr_q] == OP_ILLEGAL) begin
                        // trapped locally: the logic unit never sees this opcode
                        res_data_d  = 16'h0000;
                        res_err_d   = 1'b1;
                        res_valid_d = 1'b1;
                        state_d     = HOLD;
                    end else begin
                        log_op_d  = fifo_op_q[rd_ptr_q];
                        log_opa_d = fifo_opa_q[rd_ptr_q];
                        log_opb_d = fifo_opb_q[rd_ptr_q];
                        wait_d    = 4'(LAT);
                        state_d   = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    res_data_d  = log_out;
                    res_err_d   = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        fifo_op_q  <= fifo_op_d;
        fifo_opa_q <= fifo_opa_d;
        fifo_opb_q <= fifo_opb_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wait_q      <= 4'd0;
            log_op_q    <= 3'b000;
            log_opa_q   <= 16'h0000;
            log_opb_q   <= 16'h0000;
            res_valid_q <= 1'b0;
            res_data_q  <= 16'h0000;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wait_q      <= wait_d;
            log_op_q    <= log_op_d;
            log_opa_q   <= log_opa_d;
            log_opb_q   <= log_opb_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
        end
    end
endmodule

// File: tb/tb_log_issue.sv
// Bench for log_issue: directed timing steps plus randomized traffic, checked
// against an acceptance-order queue of results computed from the opcode table.
module tb_log_issue;
    localparam int DEPTH = 4;
    localparam int LAT   = 1;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [15:0]   in_opa;
    logic [15:0]   in_opb;
    logic [2:0]    log_op;
    logic [15:0]   log_opa;
    logic [15:0]   log_opb;
    logic [15:0]   log_out;
    logic          res_valid;
    logic          res_ready;
    logic [15:0]   res_data;
    logic          res_err;
    logic          busy;
    logic [CW-1:0] count;

    int tests = 0;
    int fails = 0;
    logic [16:0] sb [$];
    logic [16:0] mon_exp;

    always #5 clk = ~clk;

    log_issue #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_opa(in_opa), .in_opb(in_opb),
        .log_op(log_op), .log_opa(log_opa), .log_opb(log_opb), .log_out(log_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_err(res_err), .busy(busy), .count(count)
    );

    function automatic logic [15:0] lu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return ~(a & b);
            3'b010:  return a | b;
            3'b011:  return ~(a | b);
            3'b100:  return a ^ b;
            3'b101:  return ~(a ^ b);
            3'b110:  return ~a;
            default: return 16'h0000;
        endcase
    endfunction

    // behavioural logic unit
    assign log_out = lu(log_op, log_opa, log_opb);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_opa   = a;
        in_opb   = b;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        check("push_accept", 32'(in_ready), 32'(1));
        step();
        in_valid = 1'b0;
    endtask

    task automatic get_res(input string tag, input logic [15:0] d, input logic e);
        int n = 0;
        while (!res_valid && n < 50) begin
            step();
            n++;
        end
        check({tag, "_valid"}, 32'(res_valid), 32'(1));
        check({tag, "_data"}, 32'(res_data), 32'(d));
        check({tag, "_err"}, 32'(res_err), 32'(e));
        step();
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        res_ready = 1'b1;
        while (busy && n < 400) begin
            step();
            n++;
        end
        check("drain_idle", 32'(busy), 32'(0));
        check("drain_sb_empty", 32'(sb.size()), 32'(0));
    endtask

    // scoreboard: expected results in acceptance order
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            check("in_ready_rule", 32'(in_ready), 32'(count != CW'(DEPTH)));
            check("log_op_never_illegal", 32'(log_op != 3'b111), 32'(1));
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_result", 32'(res_valid), 32'(0));
                end else begin
                    mon_exp = sb.pop_front();
                    check("sb_data", 32'(res_data), 32'(mon_exp[15:0]));
                    check("sb_err", 32'(res_err), 32'(mon_exp[16]));
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back((in_op == 3'b111) ? {1'b1, 16'h0000} : {1'b0, lu(in_op, in_opa, in_opb)});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = 3'b000; in_opa = 16'h0; in_opb = 16'h0; res_ready = 1'b0;
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_res_valid", 32'(res_valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_count", 32'(count), 32'(0));
        check("rst_log_op", 32'(log_op), 32'(0));
        rst = 1'b0;
        step();
        check("post_rst_in_ready", 32'(in_ready), 32'(1));

        // single AND, result after edge LAT+2
        push(3'b000, 16'hF0F0, 16'hFF00);
        check("and_count", 32'(count), 32'(1));
        step();
        check("and_issue_op", 32'(log_op), 32'(0));
        check("and_issue_opa", 32'(log_opa), 32'(16'hF0F0));
        check("and_issue_opb", 32'(log_opb), 32'(16'hFF00));
        check("and_valid_e1", 32'(res_valid), 32'(0));
        step();
        check("and_valid_e2", 32'(res_valid), 32'(0));
        step();
        check("and_valid_e3", 32'(res_valid), 32'(1));
        check("and_data", 32'(res_data), 32'(16'hF000));
        check("and_err", 32'(res_err), 32'(0));
        res_ready = 1'b1;
        step();
        check("and_valid_clr", 32'(res_valid), 32'(0));
        check("and_log_kept", 32'(log_opa), 32'(16'hF0F0));
        res_ready = 1'b0;

        // backpressure fill
        push(3'b001, 16'h1234, 16'h00FF);
        push(3'b010, 16'h1234, 16'h00FF);
        push(3'b011, 16'h1234, 16'h00FF);
        push(3'b100, 16'h1234, 16'h00FF);
        push(3'b101, 16'h1234, 16'h00FF);
        check("bp_count_full", 32'(count), 32'(DEPTH));
        check("bp_in_ready", 32'(in_ready), 32'(0));
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", 32'(res_valid), 32'(1));
            check("stall_data", 32'(res_data), 32'(16'hFFCB));
            check("stall_err", 32'(res_err), 32'(0));
            check("stall_busy", 32'(busy), 32'(1));
            step();
        end
        res_ready = 1'b1;
        get_res("bp_nand", 16'hFFCB, 1'b0);
        get_res("bp_or", 16'h12FF, 1'b0);
        get_res("bp_nor", 16'hED00, 1'b0);
        get_res("bp_xor", 16'h12CB, 1'b0);
        get_res("bp_xnor", 16'hED34, 1'b0);
        drain();

        // full FIFO with a push waiting while the head is popped
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(3'($urandom_range(0, 6)), 16'($urandom), 16'($urandom));
        end
        in_valid = 1'b1; in_op = 3'b100; in_opa = 16'hA5A5; in_opb = 16'h0FF0;
        res_ready = 1'b1;
        step();
        check("full_hold_count", 32'(count), 32'(DEPTH));
        check("full_hold_ready", 32'(in_ready), 32'(0));
        step();
        check("full_pop_count", 32'(count), 32'(DEPTH - 1));
        check("full_pop_ready", 32'(in_ready), 32'(1));
        step();
        check("full_refill_count", 32'(count), 32'(DEPTH));
        in_valid = 1'b0;
        drain();

        // illegal then legal
        res_ready = 1'b0;
        push(3'b111, 16'hBEEF, 16'hCAFE);
        push(3'b110, 16'h00FF, 16'h1111);
        check("ill_valid_e1", 32'(res_valid), 32'(1));
        check("ill_data", 32'(res_data), 32'(0));
        check("ill_err", 32'(res_err), 32'(1));
        res_ready = 1'b1;
        get_res("ill_first", 16'h0000, 1'b1);
        get_res("ill_second", 16'hFF00, 1'b0);
        drain();

        // reset while one command is in WAIT and two are queued
        res_ready = 1'b0;
        push(3'b010, 16'h0F0F, 16'h00F0);
        push(3'b000, 16'hFFFF, 16'h1234);
        push(3'b100, 16'hAAAA, 16'h5555);
        check("mid_count", 32'(count), 32'(2));
        check("mid_no_result", 32'(res_valid), 32'(0));
        rst = 1'b1;
        step();
        check("mid_rst_in_ready", 32'(in_ready), 32'(0));
        check("mid_rst_count", 32'(count), 32'(0));
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_log", 32'({log_op, log_opa, log_opb} == 35'd0), 32'(1));
        check("mid_rst_res", 32'({res_valid, res_data, res_err} == 18'd0), 32'(1));
        rst = 1'b0;
        res_ready = 1'b1;
        step();
        check("mid_post_in_ready", 32'(in_ready), 32'(1));
        for (int i = 0; i < 10; i++) begin
            check("mid_no_res_valid", 32'(res_valid), 32'(0));
            step();
        end

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_op     = 3'($urandom_range(0, 7));
            in_opa    = 16'($urandom);
            in_opb    = 16'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
